// File: rtl/keypoint_merge_reader.sv
// Reads both keypoint layers and emits one raster-ordered stream tagged with its layer.
// Each layer keeps a one-entry head register. Only a head that was just popped is refetched.
module keypoint_merge_reader #(
    parameter int unsigned KP_AW  = 11,
    parameter int unsigned KP_W   = 19,
    parameter int unsigned MAX_KP = 2048
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KP_AW:0]   kp1_count,
    input  logic [KP_AW:0]   kp2_count,
    output logic [KP_AW-1:0] kp1_addr,
    input  logic [KP_W-1:0]  kp1_dout,
    output logic [KP_AW-1:0] kp2_addr,
    input  logic [KP_W-1:0]  kp2_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [KP_W-1:0]  out_data,
    output logic             out_layer,
    output logic             busy,
    output logic             done,
    output logic [KP_AW:0]   out_count
);

    localparam int CW = KP_AW + 1;

    typedef enum logic [2:0] {StIdle, StFetch, StLoad, StMerge, StFin} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]    cnt1_q, cnt2_q, ptr1_q, ptr2_q;
    logic [KP_W-1:0]  h1_q, h2_q;
    logic             h1v_q, h2v_q;
    logic             rl1_q, rl2_q;
    logic [CW-1:0]    clamp1, clamp2, ptr1_inc, ptr2_inc;
    logic             out_free, pick1, do_pick;

    assign clamp1   = (kp1_count > CW'(MAX_KP)) ? CW'(MAX_KP) : kp1_count;
    assign clamp2   = (kp2_count > CW'(MAX_KP)) ? CW'(MAX_KP) : kp2_count;
    assign ptr1_inc = ptr1_q + 1'b1;
    assign ptr2_inc = ptr2_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (clamp1 == '0 && clamp2 == '0) ? StFin : StFetch;
                end
            end
            StFetch: state_d = StLoad;
            StLoad:  state_d = StMerge;
            StMerge: begin
                if (out_free) begin
                    state_d = (h1v_q || h2v_q) ? StFetch : StFin;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q == StFetch) || (state_q == StLoad) || (state_q == StMerge);
        done     = (state_q == StFin);
        out_free = !out_valid || out_ready;
        // Ties go to layer 0, keeping equal keys in layer order.
        pick1    = h1v_q && (!h2v_q || (h1_q <= h2_q));
        do_pick  = (state_q == StMerge) && out_free && (h1v_q || h2v_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            ptr1_q    <= '0;
            ptr2_q    <= '0;
            kp1_addr  <= '0;
            kp2_addr  <= '0;
            h1_q      <= '0;
            h2_q      <= '0;
            h1v_q     <= 1'b0;
            h2v_q     <= 1'b0;
            rl1_q     <= 1'b0;
            rl2_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_layer <= 1'b0;
            out_count <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_count <= out_count + 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        cnt1_q    <= clamp1;
                        cnt2_q    <= clamp2;
                        ptr1_q    <= '0;
                        ptr2_q    <= '0;
                        kp1_addr  <= '0;
                        kp2_addr  <= '0;
                        h1v_q     <= 1'b0;
                        h2v_q     <= 1'b0;
                        rl1_q     <= 1'b1;
                        rl2_q     <= 1'b1;
                        out_count <= '0;
                    end
                end
                StLoad: begin
                    if (rl1_q) begin
                        h1v_q <= (ptr1_q < cnt1_q);
                        h1_q  <= kp1_dout;
                    end
                    if (rl2_q) begin
                        h2v_q <= (ptr2_q < cnt2_q);
                        h2_q  <= kp2_dout;
                    end
                    rl1_q <= 1'b0;
                    rl2_q <= 1'b0;
                end
                StMerge: begin
                    if (do_pick) begin
                        out_valid <= 1'b1;
                        out_data  <= pick1 ? h1_q : h2_q;
                        out_layer <= !pick1;
                        if (pick1) begin
                            ptr1_q   <= ptr1_inc;
                            kp1_addr <= ptr1_inc[KP_AW-1:0];
                            h1v_q    <= 1'b0;
                            rl1_q    <= 1'b1;
                        end else begin
                            ptr2_q   <= ptr2_inc;
                            kp2_addr <= ptr2_inc[KP_AW-1:0];
                            h2v_q    <= 1'b0;
                            rl2_q    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
